// File: rtl/stage_pkg.sv
// Shared definitions for the two-stage accumulator processor controllers.
// Holds the opcode map (common to stage 0 and stage 1), the one-hot state
// encodings of the stage-1 FSM, the datapath control-word field positions,
// the ALU select encodings, the idle control word and small decode helpers.
package stage_pkg;

    localparam int CTRL_W = 12;

    // Opcodes, instr[7:3]
    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LDA = 5'b00001;
    localparam logic [4:0] OP_STA = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_BRA = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_NOT = 5'b01100;
    localparam logic [4:0] OP_SHL = 5'b01101;

    // Stage-1 FSM states, one-hot
    typedef logic [6:0] state_t;
    localparam state_t S_IDLE = 7'b0000001;
    localparam state_t S_ACK  = 7'b0000010;
    localparam state_t S_DEC  = 7'b0000100;
    localparam state_t S_ADDR = 7'b0001000;
    localparam state_t S_MEM  = 7'b0010000;
    localparam state_t S_EXEC = 7'b0100000;
    localparam state_t S_FLAG = 7'b1000000;

    // Control word field positions
    localparam int CB_ALU_HI     = 11;
    localparam int CB_ALU_LO     = 9;
    localparam int CB_ACC_LD     = 8;
    localparam int CB_MAR_LD     = 7;
    localparam int CB_MEM_RD     = 6;
    localparam int CB_MEM_WR     = 5;
    localparam int CB_MDR_LD     = 4;
    localparam int CB_ACC_TO_MDR = 3;
    localparam int CB_CCR_LD     = 2;
    localparam int CB_IR1_LD     = 1;
    localparam int CB_BUSY       = 0;

    // ALU select encodings
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_SHL  = 3'b110;
    localparam logic [2:0] ALU_HOLD = 3'b111;

    // ALU holding, every strobe low
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 12'hE00;

    // Ops that touch memory (go through S_ADDR/S_MEM)
    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Accumulator-only ops (straight to S_EXEC)
    function automatic logic is_acc_op(input logic [4:0] op);
        return (op == OP_NOT) || (op == OP_SHL);
    endfunction

    function automatic logic [2:0] alu_sel_of(input logic [4:0] op);
        logic [2:0] sel;
        sel = ALU_HOLD;
        case (op)
            OP_LDA:  sel = ALU_PASS;
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_NOT:  sel = ALU_NOT;
            OP_SHL:  sel = ALU_SHL;
            default: sel = ALU_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/stage1_waitcnt.sv
// Memory wait-state down-counter for the stage-1 controller.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset (count -> 0)
//   load_i      load load_val_i (has priority over dec_i)
//   dec_i       decrement; ignored when the count is already 0
//   load_val_i  value to load
//   zero_o      count is 0
module stage1_waitcnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic [2:0] load_val_i,
    output logic       zero_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/stage1_ctrl.sv
// Stage-1 Moore controller of the accumulator processor. Accepts an
// instruction/operand from stage 0, acknowledges it, sequences the data/ALU
// half of the instruction and owns the Z condition-code flag.
// Ports:
//   clk         clock, rising edge
//   clr         asynchronous active-high reset
//   stg0_state  stage-0 "instruction ready"
//   instr       IR0_0 contents, [7:3] opcode
//   data_in     IR1_0 operand (memory address)
//   alu_zero    datapath zero detect on the accumulator result
//   stg1_state  one-cycle acknowledge to stage 0
//   ctrl        datapath control word
//   addr_out    latched operand, to MAR
//   ccr_z       Z flag
//   stage1      one-hot current state
//   stg1_instr  latched instruction (IR1)
//
// Handshake: an instruction is accepted on an edge where stg0_state=1 while
// idle and not yet taken; stg1_state then pulses for one cycle. The taken flag
// blocks re-acceptance until stg0_state has been seen low on some edge, so a
// line held high across a long execution yields exactly one acceptance.
module stage1_ctrl
    import stage_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          stg0_state,
    input  logic [7:0]    instr,
    input  logic [7:0]    data_in,
    input  logic          alu_zero,
    output logic          stg1_state,
    output logic [CW-1:0] ctrl,
    output logic [7:0]    addr_out,
    output logic          ccr_z,
    output logic [6:0]    stage1,
    output logic [7:0]    stg1_instr
);

    // Counter reload so that S_MEM lasts exactly MEM_WAIT cycles
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic       taken_q, taken_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] addr_q, addr_d;
    logic       ccr_z_q, ccr_z_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [4:0] op_q;
    logic [CTRL_W-1:0] ctrl_c;

    assign op_q = instr_q[7:3];

    stage1_waitcnt u_waitcnt (
        .clk_i      (clk),
        .rst_i      (clr),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (WAIT_LOAD),
        .zero_o     (cnt_zero)
    );

    // State and data registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            taken_q <= 1'b0;
            instr_q <= 8'd0;
            addr_q  <= 8'd0;
            ccr_z_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            ccr_z_q <= ccr_z_d;
        end
    end

    // Next state and register updates
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        ccr_z_d  = ccr_z_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        // Any edge with the request low re-arms acceptance
        if (!stg0_state) begin
            taken_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (stg0_state && !taken_q) begin
                    state_d = S_ACK;
                    taken_d = 1'b1;
                    instr_d = instr;
                    addr_d  = data_in;
                end
            end
            S_ACK: state_d = S_DEC;
            S_DEC: begin
                if (is_mem_op(op_q)) begin
                    state_d = S_ADDR;
                end else if (is_acc_op(op_q)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                cnt_load = 1'b1;
                state_d  = S_MEM;
            end
            S_MEM: begin
                if (cnt_zero) begin
                    state_d = (op_q == OP_STA) ? S_IDLE : S_EXEC;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_EXEC: state_d = S_FLAG;
            S_FLAG: begin
                ccr_z_d = alu_zero;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        ctrl_c     = CTRL_IDLE;
        stg1_state = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_ACK: begin
                stg1_state          = 1'b1;
                ctrl_c[CB_IR1_LD]   = 1'b1;
                ctrl_c[CB_BUSY]     = 1'b1;
            end
            S_DEC: ctrl_c[CB_BUSY] = 1'b1;
            S_ADDR: begin
                ctrl_c[CB_MAR_LD]   = 1'b1;
                ctrl_c[CB_BUSY]     = 1'b1;
            end
            S_MEM: begin
                ctrl_c[CB_BUSY] = 1'b1;
                if (op_q == OP_STA) begin
                    ctrl_c[CB_MEM_WR]     = 1'b1;
                    ctrl_c[CB_ACC_TO_MDR] = 1'b1;
                end else begin
                    ctrl_c[CB_MEM_RD] = 1'b1;
                    // Data is captured on the last wait cycle only
                    ctrl_c[CB_MDR_LD] = cnt_zero;
                end
            end
            S_EXEC: begin
                ctrl_c[CB_ALU_HI:CB_ALU_LO] = alu_sel_of(op_q);
                ctrl_c[CB_ACC_LD]           = 1'b1;
                ctrl_c[CB_BUSY]             = 1'b1;
            end
            S_FLAG: begin
                ctrl_c[CB_CCR_LD] = 1'b1;
                ctrl_c[CB_BUSY]   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl       = ctrl_c;
    assign addr_out   = addr_q;
    assign ccr_z      = ccr_z_q;
    assign stage1     = state_q;
    assign stg1_instr = instr_q;

endmodule

// File: tb/tb_stage1_ctrl.sv
// Bench for stage1_ctrl: two instances (MEM_WAIT=1 and MEM_WAIT=3) share one
// stimulus stream. A transaction-level model predicts each instance's outputs
// from the offset since acceptance; expectations are queued at every active
// edge and a monitor pops and compares them on the falling edge.
module tb_stage1_ctrl;
    import stage_pkg::S_IDLE;
    import stage_pkg::S_ACK;
    import stage_pkg::S_DEC;
    import stage_pkg::S_ADDR;
    import stage_pkg::S_MEM;
    import stage_pkg::S_EXEC;
    import stage_pkg::S_FLAG;

    localparam int EW = 37; // {state7, ack, ctrl12, addr8, instr8, z}

    localparam logic [4:0] T_LDA = 5'b00001;
    localparam logic [4:0] T_STA = 5'b00010;
    localparam logic [4:0] T_ADD = 5'b00011;
    localparam logic [4:0] T_SUB = 5'b00100;
    localparam logic [4:0] T_AND = 5'b01010;
    localparam logic [4:0] T_OR  = 5'b01011;
    localparam logic [4:0] T_NOT = 5'b01100;
    localparam logic [4:0] T_SHL = 5'b01101;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       stg0_state = 1'b0;
    logic [7:0] instr = 8'd0;
    logic [7:0] data_in = 8'd0;
    logic       alu_zero = 1'b0;

    logic        ack0, ack1, z0, z1;
    logic [11:0] ctrl0, ctrl1;
    logic [7:0]  addr0, addr1, ins0, ins1;
    logic [6:0]  st0, st1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    event abort_ev;

    logic [4:0] op_tab[10] = '{T_LDA, T_STA, T_ADD, T_SUB, T_AND, T_OR,
                               T_NOT, T_SHL, 5'b00000, 5'b00110};

    always #5 clk = ~clk;

    stage1_ctrl #(.MEM_WAIT(1), .CW(12)) u_dut1 (
        .clk(clk), .clr(clr), .stg0_state(stg0_state), .instr(instr),
        .data_in(data_in), .alu_zero(alu_zero), .stg1_state(ack0),
        .ctrl(ctrl0), .addr_out(addr0), .ccr_z(z0), .stage1(st0),
        .stg1_instr(ins0)
    );

    stage1_ctrl #(.MEM_WAIT(3), .CW(12)) u_dut3 (
        .clk(clk), .clr(clr), .stg0_state(stg0_state), .instr(instr),
        .data_in(data_in), .alu_zero(alu_zero), .stg1_state(ack1),
        .ctrl(ctrl1), .addr_out(addr1), .ccr_z(z1), .stage1(st1),
        .stg1_instr(ins1)
    );

    // ---------------- reference model ----------------
    function automatic bit is_mem(input logic [4:0] op);
        return op inside {T_LDA, T_STA, T_ADD, T_SUB, T_AND, T_OR};
    endfunction

    function automatic bit is_unary(input logic [4:0] op);
        return op inside {T_NOT, T_SHL};
    endfunction

    function automatic logic [2:0] alu_of(input logic [4:0] op);
        case (op)
            T_LDA:   return 3'b000;
            T_ADD:   return 3'b001;
            T_SUB:   return 3'b010;
            T_AND:   return 3'b011;
            T_OR:    return 3'b100;
            T_NOT:   return 3'b101;
            T_SHL:   return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Offset after acceptance at which the controller is idle again
    function automatic int seq_len(input logic [4:0] op, input int mw);
        if (op == T_STA) return 4 + mw;
        if (is_mem(op))  return 6 + mw;
        if (is_unary(op)) return 5;
        return 3;
    endfunction

    // Offset of the flag-update cycle, -1 when the op never updates Z
    function automatic int flag_k(input logic [4:0] op, input int mw);
        if (op == T_STA) return -1;
        if (is_mem(op) || is_unary(op)) return seq_len(op, mw) - 1;
        return -1;
    endfunction

    function automatic logic [EW-1:0] expect_at(input int k, input int mw,
            input logic [7:0] ins, input logic [7:0] adr, input logic z);
        logic [4:0]  op;
        logic [6:0]  st;
        logic        ack;
        logic [11:0] cw;
        int          exec_k;
        op = ins[7:3];
        st = S_IDLE;
        ack = 1'b0;
        cw = 12'hE00;
        exec_k = is_mem(op) ? 4 + mw : 3;
        if (k != 0) begin
            cw[0] = 1'b1;
            if (k == 1) begin
                st = S_ACK; ack = 1'b1; cw[1] = 1'b1;
            end else if (k == 2) begin
                st = S_DEC;
            end else if (is_mem(op) && k == 3) begin
                st = S_ADDR; cw[7] = 1'b1;
            end else if (is_mem(op) && k < exec_k) begin
                st = S_MEM;
                if (op == T_STA) begin
                    cw[5] = 1'b1; cw[3] = 1'b1;
                end else begin
                    cw[6] = 1'b1;
                    cw[4] = (k == exec_k - 1);
                end
            end else if (k == exec_k) begin
                st = S_EXEC; cw[11:9] = alu_of(op); cw[8] = 1'b1;
            end else begin
                st = S_FLAG; cw[2] = 1'b1;
            end
        end
        return {st, ack, cw, adr, ins, z};
    endfunction

    int         m_k[2];
    logic       m_taken[2];
    logic [7:0] m_instr[2];
    logic [7:0] m_addr[2];
    logic       m_z[2];

    always @(posedge clk or posedge clr) begin
        logic [EW-1:0] e;
        int mw;
        for (int d = 0; d < 2; d++) begin
            mw = (d == 0) ? 1 : 3;
            if (clr) begin
                m_k[d] = 0; m_taken[d] = 1'b0; m_instr[d] = 8'd0;
                m_addr[d] = 8'd0; m_z[d] = 1'b0;
            end else begin
                if (m_k[d] == 0) begin
                    if (stg0_state && !m_taken[d]) begin
                        m_instr[d] = instr; m_addr[d] = data_in;
                        m_taken[d] = 1'b1; m_k[d] = 1;
                    end
                end else begin
                    if (m_k[d] == flag_k(m_instr[d][7:3], mw)) m_z[d] = alu_zero;
                    m_k[d] = m_k[d] + 1;
                    if (m_k[d] == seq_len(m_instr[d][7:3], mw)) m_k[d] = 0;
                end
                if (!stg0_state) m_taken[d] = 1'b0;
            end
            e = expect_at(m_k[d], mw, m_instr[d], m_addr[d], m_z[d]);
            if (d == 0) begin
                if (clr) exp_q0.delete();
                exp_q0.push_back(e);
            end else begin
                if (clr) exp_q1.delete();
                exp_q1.push_back(e);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cmp_dut(input string tag, input logic [EW-1:0] e,
            input logic [6:0] st, input logic ack, input logic [11:0] cw,
            input logic [7:0] adr, input logic [7:0] ins, input logic z);
        chk({tag, ".stage1"},     32'(st),  32'(e[36:30]));
        chk({tag, ".stg1_state"}, 32'(ack), 32'(e[29]));
        chk({tag, ".ctrl"},       32'(cw),  32'(e[28:17]));
        chk({tag, ".addr_out"},   32'(adr), 32'(e[16:9]));
        chk({tag, ".stg1_instr"}, 32'(ins), 32'(e[8:1]));
        chk({tag, ".ccr_z"},      32'(z),   32'(e[0]));
    endtask

    always begin
        logic [EW-1:0] e;
        @(negedge clk or abort_ev);
        if (clk) begin
            // Mid-cycle snapshot right after an asynchronous clear: peek only
            chk("abort.q_mw1_size", 32'(exp_q0.size()), 32'd1);
            chk("abort.q_mw3_size", 32'(exp_q1.size()), 32'd1);
            if (exp_q0.size() != 0) cmp_dut("abort.mw1", exp_q0[0], st0, ack0, ctrl0, addr0, ins0, z0);
            if (exp_q1.size() != 0) cmp_dut("abort.mw3", exp_q1[0], st1, ack1, ctrl1, addr1, ins1, z1);
        end else begin
            if (exp_q0.size() == 0) begin
                total_cnt++;
                $display("FAIL mw1.scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q0.pop_front();
                cmp_dut("mw1", e, st0, ack0, ctrl0, addr0, ins0, z0);
            end
            if (exp_q1.size() == 0) begin
                total_cnt++;
                $display("FAIL mw3.scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q1.pop_front();
                cmp_dut("mw3", e, st1, ack1, ctrl1, addr1, ins1, z1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ins, input logic [7:0] adr,
            input logic az, input int hold, input int gap);
        instr = ins; data_in = adr; alu_zero = az; stg0_state = 1'b1;
        tick(hold);
        stg0_state = 1'b0;
        tick(gap);
    endtask

    initial begin
        tick(3);
        clr = 1'b0;
        tick(2);
        issue(8'b00001000, 8'h3C, 1'b1, 1, 12);   // LDA, Z -> 1
        issue(8'b00010000, 8'h55, 1'b0, 1, 12);   // STA, Z unchanged
        issue(8'b00011001, 8'hA0, 1'b1, 20, 1);   // ADD, line held 20 cycles
        issue(8'b01010000, 8'h0F, 1'b1, 1, 14);   // AND after 1-cycle drop
        issue(8'b00110000, 8'hEE, 1'b0, 1, 6);    // BRA, ack-only
        issue(8'b00100000, 8'h11, 1'b0, 1, 12);   // SUB, Z -> 0
        issue(8'b01100000, 8'h22, 1'b1, 1, 8);    // NOT
        issue(8'b01101000, 8'h33, 1'b0, 1, 8);    // SHL
        // Asynchronous clear while both instances sit in S_MEM
        instr = 8'b00001000; data_in = 8'h77; alu_zero = 1'b1; stg0_state = 1'b1;
        tick(1);
        stg0_state = 1'b0;
        tick(3);
        clr = 1'b1;
        #1;
        -> abort_ev;
        tick(2);
        clr = 1'b0;
        tick(3);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stg0_state = ($urandom_range(0, 2) != 0);
            instr = {op_tab[$urandom_range(0, 9)], 3'($urandom_range(0, 7))};
            data_in = 8'($urandom_range(0, 255));
            alu_zero = 1'($urandom_range(0, 1));
            tick(1);
        end
        stg0_state = 1'b0;
        tick(14);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
